// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the core pipeline stage registers.
//   pipe_state_t : occupancy of a stage register (EMPTY / ONE / TWO beats held)
//   NOP_INSTR    : bubble value for instruction-carrying lanes (addi x0,x0,0)
//   *_t structs  : per-stage payload layouts; $bits() of each sets the WIDTH
//                  parameter of the pipe_stage_reg placed between the stages.
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Two-entry (main + skid) elastic buffer. in_ready is decoded purely from the
// state register, so there is no combinational path from out_ready to
// in_ready; the skid entry absorbs the one beat that arrives while the
// downstream stall is still propagating.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   clr                  discard both entries on the next edge (flush)
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (main entry)
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             emit;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;   // empty entries are parked at BUBBLE

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_d = in_data;
        end else if (accept) begin
          // downstream stalled: the new beat waits behind main in the skid
          state_d = TWO;
          skid_d  = in_data;
        end else if (emit) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      TWO: begin
        if (emit) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase
    if (clr) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic valid/ready pipeline register placed between core pipeline stages.
// Carries one WIDTH-bit beat per cycle, injects BUBBLE when empty, supports
// flush, and counts back-pressure cycles in a saturating stall counter.
// Build option (macro PIPE_STAGE_SKID_EN):
//   defined   : two-entry skid buffer (pipe_skid_buf), in_ready registered
//   undefined : single entry, in_ready = !out_valid || out_ready
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop every held beat and any beat offered this cycle
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload
//   stall_cnt            cycles with out_valid && !out_ready (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN

  // Flush acts as a clear that overrides any accept inside the buffer, so a
  // beat offered in the flush cycle never lands.
  pipe_skid_buf #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`else

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;
  logic             emit;

  assign out_valid = (state_q == ONE);
  assign out_data  = data_q;
  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (flush) begin
      state_d = EMPTY;
      data_d  = BUBBLE;
    end else if (accept) begin
      // covers both fill-from-empty and replace-on-emit
      state_d = ONE;
      data_d  = in_data;
    end else if (emit) begin
      state_d = EMPTY;
      data_d  = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

`endif

  // Back-pressure counter: survives flush, cleared only by reset.
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
